// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780-style character-LCD bus sequencer.
// The power-up init sequence is built only when LCD_INIT_EN is defined.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        WAIT,
        INIT_PWR,
        INIT_LOAD
    } lcd_state_t;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    // Clear and home take ~1.6 ms on the panel instead of ~40 us.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// Request handshake and packed LCD pin word between the IO decode and lcd_controller.
interface lcd_controller_if;
    logic        i_req_valid;
    logic        i_req_rs;
    logic [7:0]  i_req_data;
    logic        o_req_ready;
    logic        o_done;
    logic        o_busy;
    logic [31:0] o_io_lcd;

    modport master (
        output i_req_valid, i_req_rs, i_req_data,
        input  o_req_ready, o_done, o_busy, o_io_lcd
    );

    modport slave (
        input  i_req_valid, i_req_rs, i_req_data,
        output o_req_ready, o_done, o_busy, o_io_lcd
    );
endinterface

// File: rtl/lcd_init_rom.sv
// Power-up command sequence for the panel: 8-bit bus, 2 lines, display on, cursor increment.
module lcd_init_rom
    import lcd_ctrl_pkg::*;
(
    input  logic [2:0] index,
    output logic [7:0] data,
    output logic       last
);
    always_comb begin
        data = CMD_FUNC_8B2L;
        last = 1'b0;
        case (index)
            3'd0, 3'd1, 3'd2: data = CMD_FUNC_8B2L;
            3'd3:             data = CMD_DISP_ON;
            3'd4:             data = CMD_CLEAR;
            default: begin
                data = CMD_ENTRY_INC;
                last = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/lcd_controller.sv
// HD44780-style bus-cycle sequencer: setup, EN pulse, hold and execution wait per byte.
// Define LCD_INIT_EN to run the built-in power-up init sequence after reset.
module lcd_controller
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_CLEAR_CYC = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    lcd_controller_if.slave bus
);
    localparam int MAX_CYC = max_of(max_of(max_of(T_SETUP_CYC, T_EN_CYC), max_of(T_HOLD_CYC, T_EXEC_CYC)),
                                    max_of(T_CLEAR_CYC, T_PWRUP_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    function automatic logic [CW-1:0] load_val(input int cycles);
        return CW'(cycles - 1);
    endfunction

    lcd_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   io_reg, io_next;
    logic          wait_end;
    logic          ext_end;
    logic          ready;
    logic          accept;

`ifdef LCD_INIT_EN
    logic [2:0] idx_reg, idx_next;
    logic       init_reg, init_next;
    logic       last_reg, last_next;
    logic       rom_load;
    logic [7:0] rom_data;
    logic       rom_last;

    lcd_init_rom u_init_rom (
        .index (idx_reg),
        .data  (rom_data),
        .last  (rom_last)
    );
`endif

    // Ready is raised in the final WAIT cycle so a waiting request chains with no idle gap.
    assign wait_end = (state_reg == WAIT) && (cnt_reg == '0);
`ifdef LCD_INIT_EN
    assign ext_end = wait_end && !init_reg;
`else
    assign ext_end = wait_end;
`endif
    assign ready  = (state_reg == IDLE) || ext_end;
    assign accept = ready && bus.i_req_valid;

    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg == '0) ? '0 : cnt_reg - CW'(1);
        io_next    = io_reg;
        io_next[LCD_ON_BIT] = 1'b1;
        io_next[LCD_EN_BIT] = 1'b0;
        io_next[LCD_RW_BIT] = 1'b0;
`ifdef LCD_INIT_EN
        idx_next  = idx_reg;
        init_next = init_reg;
        last_next = last_reg;
        rom_load  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next          = EN_HI;
                    cnt_next            = load_val(T_EN_CYC);
                    io_next[LCD_EN_BIT] = 1'b1;
                end
            end
            EN_HI: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = load_val(T_HOLD_CYC);
                end else begin
                    io_next[LCD_EN_BIT] = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = WAIT;
                    cnt_next   = is_slow_cmd(io_reg[LCD_RS_BIT], io_reg[7:0]) ?
                                 load_val(T_CLEAR_CYC) : load_val(T_EXEC_CYC);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
`ifdef LCD_INIT_EN
                    if (init_reg) begin
                        if (last_reg) init_next = 1'b0;
                        else          rom_load  = 1'b1;
                    end
`endif
                end
            end
            INIT_PWR: begin
                if (cnt_reg == '0) state_next = INIT_LOAD;
            end
            INIT_LOAD: begin
`ifdef LCD_INIT_EN
                rom_load = 1'b1;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            io_next[LCD_RS_BIT] = bus.i_req_rs;
            io_next[7:0]        = bus.i_req_data;
            state_next          = SETUP;
            cnt_next            = load_val(T_SETUP_CYC);
        end
`ifdef LCD_INIT_EN
        if (rom_load) begin
            io_next[LCD_RS_BIT] = 1'b0;
            io_next[7:0]        = rom_data;
            idx_next            = idx_reg + 3'd1;
            last_next           = rom_last;
            state_next          = SETUP;
            cnt_next            = load_val(T_SETUP_CYC);
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            io_reg <= '0;
`ifdef LCD_INIT_EN
            // Reset is the entry into INIT_PWR; INIT_LOAD supplies the last power-up cycle.
            state_reg <= INIT_PWR;
            cnt_reg   <= load_val(T_PWRUP_CYC);
            idx_reg   <= '0;
            init_reg  <= 1'b1;
            last_reg  <= 1'b0;
`else
            state_reg <= IDLE;
            cnt_reg   <= '0;
`endif
        end else begin
            io_reg    <= io_next;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
`ifdef LCD_INIT_EN
            idx_reg   <= idx_next;
            init_reg  <= init_next;
            last_reg  <= last_next;
`endif
        end
    end

    assign bus.o_io_lcd    = io_reg;
    assign bus.o_req_ready = ready;
    assign bus.o_busy      = ~ready;
    assign bus.o_done      = ext_end;

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboarded bench for lcd_controller: driver queues expected bytes, monitor checks bus timing.
module tb_lcd_controller;
    localparam int TS = 2, TE = 4, TH = 2, TX = 10, TC = 50, TP = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_controller_if bus ();

    lcd_controller #(
        .T_SETUP_CYC (TS), .T_EN_CYC (TE), .T_HOLD_CYC (TH),
        .T_EXEC_CYC  (TX), .T_CLEAR_CYC (TC), .T_PWRUP_CYC (TP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct { logic rs; logic [7:0] data; } txn_t;
    txn_t       exp_q[$];
    logic [7:0] init_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: cycles from the accept cycle until ready/done come back.
    function automatic int exp_latency(input logic rs, input logic [7:0] d);
        int wait_cyc;
        wait_cyc = (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) ? TC : TX;
        return TS + TE + TH + wait_cyc;
    endfunction

    task automatic push_init_bytes();
        init_q = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit         active = 0;
        int         acc_cyc = 0;
        logic       prev_en = 1'b0;
        int         en_rise = 0;
        logic [8:0] en_pay = '0;
        logic [8:0] cur_pay;
        bit         stable = 1;
        int         pulses = 0;
        int         k;
        logic       en;
        txn_t       t;
        forever begin
            @(negedge clk);
            en      = bus.o_io_lcd[10];
            cur_pay = {bus.o_io_lcd[9], bus.o_io_lcd[7:0]};
            if (!rst_n) begin
                if (active) void'(exp_q.pop_front());
                active  = 0;
                prev_en = 1'b0;
                continue;
            end
            if (active) begin
                t = exp_q[0];
                k = cyc - acc_cyc;
                if (en && !prev_en) begin
                    pulses++;
                    en_rise = k;
                    en_pay  = cur_pay;
                    stable  = 1;
                    check("en_rise_cycle", k, TS + 1);
                    check("en_payload", cur_pay, {t.rs, t.data});
                end
                if (en && prev_en && cur_pay != en_pay) stable = 0;
                if (!en && prev_en) begin
                    check("en_width", k - en_rise, TE);
                    check("data_stable_during_en", stable, 1);
                end
                if (bus.o_req_ready) begin
                    check("ready_latency", k, exp_latency(t.rs, t.data));
                    check("done_with_ready", bus.o_done, 1);
                    check("en_pulses_per_txn", pulses, 1);
                    $display("txn rs=%0b data=%02h ready_after=%0d en_pulses=%0d", t.rs, t.data, k, pulses);
                    void'(exp_q.pop_front());
                    active = 0;
                end else if (bus.o_done) begin
                    check("done_while_busy", bus.o_done, 0);
                end
            end else begin
                if (en && !prev_en) begin
                    if (init_q.size() > 0) begin
                        check("init_byte", cur_pay, {1'b0, init_q[0]});
                        $display("init byte rs=%0b data=%02h", cur_pay[8], cur_pay[7:0]);
                        void'(init_q.pop_front());
                    end else begin
                        check("spurious_en", en, 0);
                    end
                end
                if (bus.o_done) check("spurious_done", bus.o_done, 0);
            end
            prev_en = en;
            if (bus.i_req_valid && bus.o_req_ready) begin
                check("unexpected_accept", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("accept_payload", {bus.i_req_rs, bus.i_req_data}, {exp_q[0].rs, exp_q[0].data});
                    active  = 1;
                    acc_cyc = cyc;
                    pulses  = 0;
                    prev_en = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic rs, input logic [7:0] d, input bit jitter);
        exp_q.push_back('{rs: rs, data: d});
        bus.i_req_rs    = rs;
        bus.i_req_data  = d;
        bus.i_req_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.i_req_valid && bus.o_req_ready) break;
            if (n > 400) begin
                check("accept_timeout", bus.o_req_ready, 1);
                bus.i_req_valid = 1'b0;
                void'(exp_q.pop_back());
                return;
            end
            @(posedge clk); #1;
            if (jitter && !bus.o_req_ready) bus.i_req_valid = 1'($urandom_range(0, 1));
            else                            bus.i_req_valid = 1'b1;
        end
        @(posedge clk); #1;
        last_acc        = cyc;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input int budget);
        for (int n = 0; n < budget && !bus.o_req_ready; n++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int         a0, a1, a2, low_cnt;
        logic       rs;
        logic [7:0] d;
        bus.i_req_valid = 1'b0;
        bus.i_req_rs    = 1'b0;
        bus.i_req_data  = 8'h00;
`ifdef LCD_INIT_EN
        push_init_bytes();
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_io_lcd", bus.o_io_lcd, 32'h0);
        check("reset_done", bus.o_done, 0);
`ifdef LCD_INIT_EN
        check("reset_ready", bus.o_req_ready, 0);
`else
        check("reset_ready", bus.o_req_ready, 1);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("on_after_release", bus.o_io_lcd, 32'h8000_0000);
`ifdef LCD_INIT_EN
        low_cnt = 0;
        while (!bus.o_req_ready && low_cnt < 2000) begin
            low_cnt++;
            @(posedge clk); #1;
        end
        check("init_ready_low_cycles", low_cnt, TP + 5 * (TS + TE + TH + TX) + (TS + TE + TH + TC));
        check("init_bytes_left", init_q.size(), 0);
`else
        check("ready_after_release", bus.o_req_ready, 1);
        check("busy_after_release", bus.o_busy, 0);
`endif

        // Directed: character, slow command, ordinary command.
        send(1'b1, 8'h41, 0); wait_idle();
        send(1'b0, 8'h01, 0); wait_idle();
        send(1'b0, 8'h80, 0); wait_idle();
        send(1'b0, 8'h03, 0); wait_idle();

        // Valid held high across three queued bytes.
        send(1'b1, 8'h48, 0); a0 = last_acc;
        send(1'b1, 8'h49, 0); a1 = last_acc;
        send(1'b1, 8'h21, 0); a2 = last_acc;
        check("b2b_gap_1", a1 - a0, exp_latency(1'b1, 8'h48));
        check("b2b_gap_2", a2 - a1, exp_latency(1'b1, 8'h49));
        wait_idle();

        // Reset while EN is high abandons the transfer.
        send(1'b1, 8'h55, 0);
        for (int n = 0; n < 20 && !bus.o_io_lcd[10]; n++) begin
            @(posedge clk); #1;
        end
        check("en_before_reset", bus.o_io_lcd[10], 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_io_lcd", bus.o_io_lcd, 32'h0);
        check("midreset_done", bus.o_done, 0);
`ifdef LCD_INIT_EN
        push_init_bytes();
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_release_io", bus.o_io_lcd, 32'h8000_0000);
`ifdef LCD_INIT_EN
        wait_ready(2000);
`endif
        check("midreset_release_ready", bus.o_req_ready, 1);
        repeat (30) @(posedge clk);
        #1;

        // Randomised traffic with valid dropped and re-raised while busy.
        for (int i = 0; i < 14; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 3));
            end
            send(rs, d, 1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (5) @(posedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
